wait_state_memory: RTL
======================

WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 Parameter ADDR_SIZE, default 16, SHALL set the width of the address port in bits.
REQ-002 Parameter DATA_SIZE, default 16, SHALL set the width of the data words in bits.
REQ-003 Parameter DEPTH_LOG2, default 8, SHALL set the storage to 2**DEPTH_LOG2 words; legal range is 1..ADDR_SIZE.
REQ-004 Parameter WAIT_CYCLES, default 4, SHALL set the number of BUSY cycles per access; legal range is 1..255.
REQ-005 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 en  input  1  SHALL be the access request (held high by the requester until ready).
REQ-008 ctrl  input  1  SHALL select the access type: 0 = read, 1 = write.
REQ-009 addr  input  ADDR_SIZE  SHALL be the word address.
REQ-010 in  input  DATA_SIZE  SHALL be the write data.
REQ-011 out  output  DATA_SIZE  SHALL be the registered read data.
REQ-012 ready  output  1  SHALL be the completion strobe (LC-3 "R"), high for exactly one cycle per access.
REQ-013 busy  output  1  SHALL be high while an access is in flight (state BUSY or DONE).
REQ-014 err  output  1  SHALL flag an out-of-range address; it is valid only while ready is high.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE; there is no other state.
REQ-016 In IDLE, when en=1 at a rising edge, the block SHALL accept the request:
- latch addr, ctrl and in;
- set a wait counter to WAIT_CYCLES-1;
- go to BUSY.
REQ-017 In BUSY, at each rising edge:
- if the counter is nonzero, decrement it and stay in BUSY;
- if the counter is zero, perform the access and go to DONE.
REQ-018 The access SHALL be performed at the BUSY-to-DONE edge:
- write: mem[latched addr] receives latched in;
- read: out receives mem[latched addr].
REQ-019 In DONE, ready=1 and err is valid; the next rising edge SHALL return the FSM to IDLE unconditionally.
REQ-020 Timing SHALL be as follows:
- ready rises after the WAIT_CYCLES-th rising edge following the acceptance edge;
- total occupancy is WAIT_CYCLES+1 cycles after acceptance.
REQ-021 While in BUSY or DONE, changes on en, ctrl, addr or in SHALL be ignored; only the latched values are used.
REQ-022 If en is still high in IDLE (the cycle after DONE), a new access SHALL be accepted; back-to-back accesses therefore have one IDLE cycle between them.
REQ-023 An address is out of range if its latched value is >= 2**DEPTH_LOG2. For such an address:
- a write SHALL not modify memory;
- a read SHALL set out to 0;
- err=1 during DONE.
REQ-024 For an in-range address, err SHALL be 0 during DONE; err SHALL be 0 in IDLE and BUSY.
REQ-025 out SHALL hold its value except at a read's BUSY-to-DONE edge; writes do not change out.
REQ-026 Only address bits [DEPTH_LOG2-1:0] SHALL index the storage, after the range check in REQ-023.
REQ-027 ready, busy and err SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-028 Storage contents SHALL not be initialised; a read of a never-written location returns an undefined value.

Reset
REQ-029 While rst=1, the block SHALL immediately force state=IDLE, counter=0, out=0, ready=0, busy=0 and err=0.
REQ-030 A reset asserted during BUSY SHALL abort the access; a pending write SHALL not be performed.
REQ-031 Memory contents SHALL be unaffected by reset.
REQ-032 After rst deasserts, the first rising edge with en=1 SHALL be accepted as a new request.

Verification
REQ-033 Write then read (WAIT_CYCLES=4): write 16'h1234 to addr 5, then read addr 5.
- Each access: ready pulses 4 edges after acceptance, for 1 cycle.
- Read: out=16'h1234, err=0.
REQ-034 Input stability: change addr to 6 and in to 16'hFFFF during BUSY of a write to addr 5.
- mem[5] receives the originally latched data; mem[6] is unchanged.
REQ-035 Out of range (DEPTH_LOG2=8): write 16'hBEEF to addr 16'h0100, then read it.
- Both accesses: err=1 with ready.
- Read: out=0; mem[0] is unchanged.
REQ-036 Reset mid-write: assert rst during the second BUSY cycle of a write of 16'hAAAA to addr 3 (mem[3] previously 16'h5555).
- ready, busy and out are 0 at once.
- A subsequent read of addr 3 returns 16'h5555.
REQ-037 Back-to-back: hold en=1 across two reads.
- ready pulses exactly once per access.
- Consecutive ready pulses are 6 cycles apart (WAIT_CYCLES+2) with 1 IDLE cycle between accesses.
REQ-038 WAIT_CYCLES=1: a read SHALL complete with ready high in the cycle immediately after the single BUSY cycle.

Source files
------------

// File: rtl/wait_state_memory.sv
// wait_state_memory: word-addressed storage behind a fixed wait-state request/ready handshake.
// Ports: clk_i, rst_i (async, active-high); en_i request, ctrl_i (0 read, 1 write), addr_i, in_i;
//        out_o registered read data, ready_o one-cycle completion, busy_o access in flight, err_o out-of-range (valid with ready_o).
module wait_state_memory #(
  parameter int ADDR_SIZE   = 16,
  parameter int DATA_SIZE   = 16,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 ctrl_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [DATA_SIZE-1:0] in_i,
  output logic [DATA_SIZE-1:0] out_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  // Counter reload: the BUSY state lasts WAIT_CYCLES cycles, the last of
  // which sees the counter at zero.
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q,   cnt_d;
  logic [ADDR_SIZE-1:0]   addr_q,  addr_d;
  logic                   ctrl_q,  ctrl_d;
  logic [DATA_SIZE-1:0]   data_q,  data_d;
  logic [DATA_SIZE-1:0]   out_q,   out_d;
  logic                   err_q,   err_d;

  logic                   addr_oor;
  logic [DEPTH_LOG2-1:0]  mem_idx;
  logic                   mem_we;

  // Storage is deliberately left out of the reset domain so a reset never
  // disturbs its contents.
  logic [DATA_SIZE-1:0]   mem [DEPTH];

  // Range check on the latched address: any set bit above the index field
  // puts it beyond the storage. When the storage spans the whole address
  // space nothing can be out of range.
  generate
    if (DEPTH_LOG2 < ADDR_SIZE) begin : g_range
      assign addr_oor = |addr_q[ADDR_SIZE-1:DEPTH_LOG2];
    end else begin : g_full
      assign addr_oor = 1'b0;
    end
  endgenerate

  assign mem_idx = addr_q[DEPTH_LOG2-1:0];

  // Next-state and access decode. Everything here depends only on
  // registered state, except the request capture in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    out_d   = out_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          addr_d  = addr_i;
          ctrl_d  = ctrl_i;
          data_d  = in_i;
          cnt_d   = WAIT_LOAD;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Final wait cycle: the access itself happens on this edge.
          state_d = DONE;
          err_d   = addr_oor;
          if (ctrl_q) begin
            mem_we = ~addr_oor;
          end else begin
            out_d = addr_oor ? '0 : mem[mem_idx];
          end
        end
      end

      DONE: begin
        // err_q is only ever set on entry to DONE and drops on exit.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      ctrl_q  <= 1'b0;
      data_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Reset forces state to IDLE asynchronously, so an aborted write can
  // never assert mem_we at the following edge.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_idx] <= data_q;
    end
  end

  assign out_o   = out_q;
  assign ready_o = (state_q == DONE);
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;

endmodule
